// File: rtl/uart_t.sv
// Transmit-only UART: one byte per request, LSB first, framed by a start bit,
// an optional parity bit and one or two stop bits.
module uart_t #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       en,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_t: CLK_FREQ/BAUD must be at least 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_t: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_t: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_end;
    logic             start_frame;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        start_frame = 1'b0;
        bit_end     = (baud_q == LAST_CNT);

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (en) begin
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        // A request on the final stop edge chains the next frame with no idle gap.
                        if (en) begin
                            start_frame = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (start_frame) begin
            state_d = S_START;
            shift_d = data;
            par_d   = (PARITY == 1) ? ~(^data) : (^data);
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_t.sv
// Bench for uart_t: four configurations share one stimulus stream and are each
// compared every cycle against a frame-level waveform model.
module tb_uart_t;

    localparam int NUM_DUT = 4;
    localparam int CPB[NUM_DUT] = '{434, 8, 8, 8};
    localparam int PAR[NUM_DUT] = '{0, 2, 1, 0};
    localparam int STP[NUM_DUT] = '{1, 1, 2, 1};

    logic                clk;
    logic                rst_n;
    logic [7:0]          data;
    logic                en;
    logic [NUM_DUT-1:0]  tx_w;
    logic [NUM_DUT-1:0]  busy_w;

    int n_checks;
    int n_errors;
    int run_len[NUM_DUT];
    int last_run[NUM_DUT];

    // Expected tx level for each remaining cycle of the frame in flight.
    bit exp_q[NUM_DUT][$];

    uart_t u0 (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .tx(tx_w[0]), .busy(busy_w[0])
    );

    uart_t #(.CLK_FREQ(800), .BAUD(100), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .tx(tx_w[1]), .busy(busy_w[1])
    );

    uart_t #(.CLK_FREQ(800), .BAUD(100), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .tx(tx_w[2]), .busy(busy_w[2])
    );

    uart_t #(.CLK_FREQ(800), .BAUD(100), .PARITY(0), .STOP_BITS(1)) u3 (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .tx(tx_w[3]), .busy(busy_w[3])
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic int frame_len(input int k);
        return (1 + 8 + ((PAR[k] != 0) ? 1 : 0) + STP[k]) * CPB[k];
    endfunction

    task automatic push_frame(input int k, input logic [7:0] d);
        bit levels[$];
        bit par_bit;
        levels.push_back(1'b0);
        for (int i = 0; i < 8; i++) levels.push_back(d[i]);
        if (PAR[k] != 0) begin
            par_bit = ($countones(d) % 2) == 1;
            if (PAR[k] == 1) par_bit = !par_bit;
            levels.push_back(par_bit);
        end
        for (int s = 0; s < STP[k]; s++) levels.push_back(1'b1);
        foreach (levels[i]) begin
            for (int c = 0; c < CPB[k]; c++) exp_q[k].push_back(levels[i]);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < NUM_DUT; k++) begin
            if (!rst_n) begin
                exp_q[k].delete();
            end else begin
                if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
                if (exp_q[k].size() == 0 && en) push_frame(k, data);
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int exp_tx;
        int exp_busy;
        for (int k = 0; k < NUM_DUT; k++) begin
            exp_busy = (exp_q[k].size() != 0) ? 1 : 0;
            exp_tx   = (exp_q[k].size() != 0) ? int'(exp_q[k][0]) : 1;
            check($sformatf("tx[u%0d]", k), int'(tx_w[k]), exp_tx);
            check($sformatf("busy[u%0d]", k), int'(busy_w[k]), exp_busy);
            if (busy_w[k] === 1'b1) begin
                run_len[k]++;
            end else if (run_len[k] != 0) begin
                last_run[k] = run_len[k];
                run_len[k]  = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] d,
                                 input int cycles);
        rst_n = r;
        en    = e;
        data  = d;
        repeat (cycles) begin
            @(negedge clk);
            checkOutput();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < NUM_DUT; k++) begin
            run_len[k]  = 0;
            last_run[k] = 0;
        end

        $display("[TB] power-up reset with en held high");
        applyStimulus(1'b0, 1'b1, 8'h7E, 5);
        check("reset_tx_all", int'(tx_w), 4'hF);
        check("reset_busy_all", int'(busy_w), 0);

        $display("[TB] 0x7E with en held two cycles after reset release");
        applyStimulus(1'b1, 1'b1, 8'h7E, 2);
        applyStimulus(1'b1, 1'b0, 8'h7E, 4400);
        for (int k = 0; k < NUM_DUT; k++) begin
            check($sformatf("frame_len_7e[u%0d]", k), last_run[k], frame_len(k));
        end
        check("idle_tx_after_7e", int'(tx_w), 4'hF);

        $display("[TB] 0xA5 with a second request while busy");
        applyStimulus(1'b1, 1'b1, 8'hA5, 1);
        applyStimulus(1'b1, 1'b0, 8'hA5, 30);
        applyStimulus(1'b1, 1'b1, 8'h00, 3);
        applyStimulus(1'b1, 1'b0, 8'h00, 120);
        check("frame_len_a5_u3", last_run[3], 80);
        check("frame_len_a5_u1", last_run[1], 88);
        check("frame_len_a5_u2", last_run[2], 96);

        $display("[TB] 0x01 odd parity");
        applyStimulus(1'b1, 1'b1, 8'h01, 1);
        applyStimulus(1'b1, 1'b0, 8'h01, 100);
        check("frame_len_01_u2", last_run[2], 96);

        $display("[TB] en held continuously with changing data");
        for (int i = 0; i < 400; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1);
        applyStimulus(1'b1, 1'b0, 8'h00, 100);

        $display("[TB] reset during data bit 3");
        applyStimulus(1'b1, 1'b1, 8'($urandom), 1);
        applyStimulus(1'b1, 1'b0, 8'h00, 34);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1);
        check("abort_tx_all", int'(tx_w), 4'hF);
        check("abort_busy_all", int'(busy_w), 0);
        applyStimulus(1'b1, 1'b1, 8'h3C, 1);
        applyStimulus(1'b1, 1'b0, 8'h3C, 4400);
        check("frame_len_after_abort_u0", last_run[0], 4340);

        $display("[TB] random requests");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'($urandom), 8'($urandom), 1 + int'($urandom_range(0, 3)));
            applyStimulus(1'b1, 1'b0, 8'($urandom), int'($urandom_range(0, 120)));
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 4400);
        check("final_tx_all", int'(tx_w), 4'hF);
        check("final_busy_all", int'(busy_w), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
